// File: rtl/nco_phase_accum_if.sv
// Config and sample port bundle for nco_phase_accum.
//   cfg_valid/cfg_ready : config handshake (source -> accumulator)
//   cfg_ftw / cfg_poff  : tuning word and phase offset, ACC_W bits each
//   cfg_sync            : 1 = apply at next accumulator wrap, 0 = apply now
//   idx_out / idx_valid : table index and new-sample strobe
//   wrap                : the step that produced this sample overflowed
// master = config source / index sink, slave = the accumulator.
interface nco_phase_accum_if #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned IDX_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [ACC_W-1:0] cfg_ftw;
   logic [ACC_W-1:0] cfg_poff;
   logic             cfg_sync;
   logic [IDX_W-1:0] idx_out;
   logic             idx_valid;
   logic             wrap;

   modport master (
      output cfg_valid, cfg_ftw, cfg_poff, cfg_sync,
      input  cfg_ready, idx_out, idx_valid, wrap
   );

   modport slave (
      input  cfg_valid, cfg_ftw, cfg_poff, cfg_sync,
      output cfg_ready, idx_out, idx_valid, wrap
   );
endinterface

// File: rtl/nco_phase_accum.sv
// NCO phase accumulator: integrates a tuning word, adds phase offset and
// optional LFSR dither, and emits the top IDX_W phase bits as a table index.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   en        : take one accumulator step this cycle
//   phase_clr : zero the accumulator (wins over en), applies a pending config
//   bus       : config handshake and index output (nco_phase_accum_if.slave)
module nco_phase_accum #(
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned IDX_W  = 8,
   parameter int unsigned DITH_W = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic phase_clr,
   nco_phase_accum_if.slave bus
);

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Selects the low DITH_W lfsr bits; all-zero when dither is disabled.
   localparam logic [15:0] DITH_MASK = 16'((17'd1 << DITH_W) - 17'd1);
   localparam bit          DITH_EN   = (DITH_W != 0);

   logic [ACC_W-1:0] acc_q,      acc_d;
   logic [ACC_W-1:0] ftw_q,      ftw_d;
   logic [ACC_W-1:0] poff_q,     poff_d;
   logic [ACC_W-1:0] sh_ftw_q,   sh_ftw_d;
   logic [ACC_W-1:0] sh_poff_q,  sh_poff_d;
   logic             pending_q,  pending_d;
   logic [15:0]      lfsr_q,     lfsr_d;
   logic [IDX_W-1:0] idx_q,      idx_d;
   logic             valid_q,    valid_d;
   logic             wrap_q,     wrap_d;
   logic             ready_q,    ready_d;

   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] phase;
   logic [ACC_W-1:0] dith;
   logic             lfsr_fb;
   logic             accept;
   logic             apply;

   // State registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q     <= '0;
         ftw_q     <= '0;
         poff_q    <= '0;
         sh_ftw_q  <= '0;
         sh_poff_q <= '0;
         pending_q <= 1'b0;
         lfsr_q    <= LFSR_SEED;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         ftw_q     <= ftw_d;
         poff_q    <= poff_d;
         sh_ftw_q  <= sh_ftw_d;
         sh_poff_q <= sh_poff_d;
         pending_q <= pending_d;
         lfsr_q    <= lfsr_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
         ready_q   <= ready_d;
      end
   end

   // Step, config accept and coherent apply
   always_comb begin
      acc_d     = acc_q;
      ftw_d     = ftw_q;
      poff_d    = poff_q;
      sh_ftw_d  = sh_ftw_q;
      sh_poff_d = sh_poff_q;
      pending_d = pending_q;
      lfsr_d    = lfsr_q;
      idx_d     = idx_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;
      apply     = 1'b0;

      sum     = {1'b0, acc_q} + {1'b0, ftw_q};
      dith    = ACC_W'(lfsr_q & DITH_MASK);
      phase   = acc_q + poff_q + dith;
      lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
      accept  = bus.cfg_valid & ready_q;

      if (phase_clr) begin
         acc_d = '0;
         apply = pending_q;
      end else if (en) begin
         acc_d   = sum[ACC_W-1:0];
         idx_d   = phase[ACC_W-1 -: IDX_W];
         valid_d = 1'b1;
         wrap_d  = sum[ACC_W];
         if (DITH_EN) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
         end
         apply = pending_q & sum[ACC_W];
      end

      // Apply and accept never coincide: ready is low while pending.
      if (apply) begin
         ftw_d     = sh_ftw_q;
         poff_d    = sh_poff_q;
         pending_d = 1'b0;
      end

      if (accept) begin
         if (bus.cfg_sync) begin
            sh_ftw_d  = bus.cfg_ftw;
            sh_poff_d = bus.cfg_poff;
            pending_d = 1'b1;
         end else begin
            ftw_d  = bus.cfg_ftw;
            poff_d = bus.cfg_poff;
         end
      end

      // Low from a sync accept until one edge after its apply.
      ready_d = ~(pending_q | pending_d);
   end

   assign bus.cfg_ready = ready_q;
   assign bus.idx_out   = idx_q;
   assign bus.idx_valid = valid_q;
   assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_nco_phase_accum.sv
// Bench for nco_phase_accum: a 32-bit undithered instance and a 16-bit
// instance with 8 dither bits, both checked every cycle against a model.
module tb_nco_phase_accum;

   localparam int unsigned AW_A = 32, IW_A = 8, DW_A = 0;
   localparam int unsigned AW_B = 16, IW_B = 8, DW_B = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic phase_clr = 1'b0;

   always #5 clk = ~clk;

   nco_phase_accum_if #(.ACC_W(AW_A), .IDX_W(IW_A)) if_a ();
   nco_phase_accum_if #(.ACC_W(AW_B), .IDX_W(IW_B)) if_b ();

   nco_phase_accum #(.ACC_W(AW_A), .IDX_W(IW_A), .DITH_W(DW_A)) dut_a (
      .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .bus(if_a));
   nco_phase_accum #(.ACC_W(AW_B), .IDX_W(IW_B), .DITH_W(DW_B)) dut_b (
      .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .bus(if_b));

   typedef struct {
      longint acc, ftw, poff, sftw, spoff;
      bit     pending;
      int     lfsr;
      longint idx;
      bit     valid, wrap, ready, accepted;
   } model_t;

   model_t ma, mb;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Behavioural reference: one clock edge of the NCO front end.
   function automatic model_t model_step(model_t m, int aw, int iw, int dw,
                                         bit rst_n, bit en_s, bit clr, bit cv,
                                         longint cftw, longint cpoff, bit csync);
      longint mask;
      longint sum;
      longint phase;
      bit     applied;
      bit     accept;
      mask       = (longint'(1) << aw) - 1;
      applied    = 1'b0;
      m.accepted = 1'b0;
      if (!rst_n) begin
         m.acc = 0; m.ftw = 0; m.poff = 0; m.pending = 1'b0;
         m.lfsr = 16'hACE1; m.idx = 0; m.valid = 1'b0; m.wrap = 1'b0;
         m.ready = 1'b0;
         return m;
      end
      accept = cv && m.ready;
      if (clr) begin
         m.acc = 0; m.valid = 1'b0; m.wrap = 1'b0;
         applied = m.pending;
      end else if (en_s) begin
         phase   = (m.acc + m.poff + longint'(m.lfsr % (1 << dw))) & mask;
         m.idx   = phase >> (aw - iw);
         sum     = m.acc + m.ftw;
         m.wrap  = (sum > mask);
         m.acc   = sum & mask;
         m.valid = 1'b1;
         if (dw > 0)
            m.lfsr = ((m.lfsr << 1) & 16'hFFFF) |
                     (((m.lfsr >> 15) ^ (m.lfsr >> 13) ^ (m.lfsr >> 12) ^ (m.lfsr >> 10)) & 1);
         applied = m.pending && m.wrap;
      end else begin
         m.valid = 1'b0; m.wrap = 1'b0;
      end
      if (applied) begin
         m.ftw = m.sftw; m.poff = m.spoff; m.pending = 1'b0;
      end
      if (accept) begin
         m.accepted = 1'b1;
         if (csync) begin
            m.sftw = cftw & mask; m.spoff = cpoff & mask; m.pending = 1'b1;
         end else begin
            m.ftw = cftw & mask; m.poff = cpoff & mask;
         end
      end
      // Port is closed while a coherent load waits, and for the apply cycle.
      m.ready = !m.pending && !applied;
      return m;
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   // One clock: advance the model on the edge, compare both DUTs 1 ns later.
   task automatic tick();
      @(posedge clk);
      ma = model_step(ma, AW_A, IW_A, DW_A, rst, en, phase_clr, if_a.cfg_valid,
                      longint'(if_a.cfg_ftw), longint'(if_a.cfg_poff), if_a.cfg_sync);
      mb = model_step(mb, AW_B, IW_B, DW_B, rst, en, phase_clr, if_b.cfg_valid,
                      longint'(if_b.cfg_ftw), longint'(if_b.cfg_poff), if_b.cfg_sync);
      #1;
      check("a_idx",   64'(if_a.idx_out),   64'(ma.idx));
      check("a_valid", 64'(if_a.idx_valid), 64'(ma.valid));
      check("a_wrap",  64'(if_a.wrap),      64'(ma.wrap));
      check("a_ready", 64'(if_a.cfg_ready), 64'(ma.ready));
      check("b_idx",   64'(if_b.idx_out),   64'(mb.idx));
      check("b_valid", 64'(if_b.idx_valid), 64'(mb.valid));
      check("b_wrap",  64'(if_b.wrap),      64'(mb.wrap));
      check("b_ready", 64'(if_b.cfg_ready), 64'(mb.ready));
      if (ma.accepted) if_a.cfg_valid = 1'b0;
      if (mb.accepted) if_b.cfg_valid = 1'b0;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Instance B sees the upper half of each config word.
   task automatic offer_cfg(logic [31:0] ftw, logic [31:0] poff, bit sync);
      if_a.cfg_ftw  = ftw;        if_a.cfg_poff = poff;        if_a.cfg_sync = sync;
      if_b.cfg_ftw  = ftw[31:16]; if_b.cfg_poff = poff[31:16]; if_b.cfg_sync = sync;
      if_a.cfg_valid = 1'b1;
      if_b.cfg_valid = 1'b1;
   endtask

   task automatic send_cfg(logic [31:0] ftw, logic [31:0] poff, bit sync);
      offer_cfg(ftw, poff, sync);
      for (int i = 0; i < 40 && (if_a.cfg_valid || if_b.cfg_valid); i++) tick();
      check("cfg_accept_timeout", 64'(if_a.cfg_valid | if_b.cfg_valid), 64'(0));
      if_a.cfg_valid = 1'b0;
      if_b.cfg_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] r_ftw;
      if_a.cfg_valid = 1'b0; if_a.cfg_ftw = '0; if_a.cfg_poff = '0; if_a.cfg_sync = 1'b0;
      if_b.cfg_valid = 1'b0; if_b.cfg_ftw = '0; if_b.cfg_poff = '0; if_b.cfg_sync = 1'b0;

      // Reset, then immediate ftw=2^24 and a free run through two rollovers.
      rst = 1'b0;
      run(2);
      rst = 1'b1;
      send_cfg(32'h0100_0000, 32'h0, 1'b0);
      en = 1'b1;
      run(520);

      // Half-turn phase offset from a cleared accumulator.
      send_cfg(32'h0100_0000, 32'h8000_0000, 1'b0);
      phase_clr = 1'b1; tick(); phase_clr = 1'b0;
      run(300);

      // Coherent load of a doubled step, mid-turn.
      send_cfg(32'h0100_0000, 32'h0, 1'b0);
      phase_clr = 1'b1; tick(); phase_clr = 1'b0;
      run(10);
      send_cfg(32'h0200_0000, 32'h0, 1'b1);
      run(300);

      // en gaps: hold and resume without skipping.
      en = 1'b0; run(2); en = 1'b1; run(3);
      for (int i = 0; i < 40; i++) begin
         en = 1'($urandom_range(0, 1));
         tick();
      end
      en = 1'b1;

      // phase_clr during a pending coherent load applies it at once.
      send_cfg(32'h0300_0000, 32'h0, 1'b1);
      run(3);
      phase_clr = 1'b1; tick(); phase_clr = 1'b0;
      run(20);

      // Reset while pending discards the shadow.
      send_cfg(32'h0500_0000, 32'h1234_5678, 1'b1);
      run(2);
      rst = 1'b0; tick(); rst = 1'b1;
      run(10);

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         en        = ($urandom_range(0, 3) != 0);
         phase_clr = ($urandom_range(0, 49) == 0);
         rst       = ($urandom_range(0, 299) != 0);
         if (!if_a.cfg_valid && !if_b.cfg_valid && $urandom_range(0, 9) == 0) begin
            r_ftw = {16'($urandom_range(16'h0100, 16'hFFFF)), 16'($urandom)};
            offer_cfg(r_ftw, 32'($urandom), 1'($urandom_range(0, 1)));
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nco_phase_accum.md
# nco_phase_accum

Phase-accumulator front end of the NCO. It integrates a programmable frequency tuning word, adds a phase offset and optional LFSR dither, and delivers a truncated sine-table index with a valid strobe. The sine lookup stage directly downstream consumes that index. Tuning word and offset are loaded through a valid/ready port and applied either immediately or phase-coherently at the next accumulator wrap.

## Interface

Parameters:
- ACC_W, 32, accumulator / tuning-word width
- IDX_W, 8, table index width (top IDX_W bits of phase)
- DITH_W, 0, dither bits added below the index LSB; 0 disables dither; legal range 0..min(16, ACC_W-IDX_W)

Ports:
- clk  in  1  single clock; everything is registered on the rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  advance the accumulator one step this cycle
- phase_clr  in  1  zero the accumulator (priority over en)
- cfg_valid  in  1  config word offered
- cfg_ready  out  1  config port can accept
- cfg_ftw  in  ACC_W  new frequency tuning word
- cfg_poff  in  ACC_W  new phase offset
- cfg_sync  in  1  1 = apply at next wrap; 0 = apply immediately
- idx_out  out  IDX_W  table index
- idx_valid  out  1  idx_out is a new sample
- wrap  out  1  the accumulation that produced this sample overflowed

## Operation

- Registers: acc, ftw_act, poff_act, shadow ftw/poff, pending, lfsr (16 bit), and the three outputs.
- Reset (rst=0 at an edge):
  - acc, ftw_act, poff_act, pending, idx_out, idx_valid and wrap all go to 0.
  - cfg_ready goes to 0, and returns to 1 on the first edge with rst=1.
  - lfsr is seeded to 16'hACE1.
- Config accept: a config word is accepted at an edge where cfg_valid & cfg_ready.
  - cfg_sync=0: ftw_act and poff_act load at that edge.
  - cfg_sync=1: the shadow registers load and pending is set to 1. cfg_ready = ~pending, as a registered value.
- Sample step, taken when en=1 and phase_clr=0:
  - sum = acc + ftw_act (ACC_W+1 bits).
  - acc <= sum[ACC_W-1:0].
  - phase = acc + poff_act + zero-extended lfsr[DITH_W-1:0], computed modulo 2^ACC_W on the pre-update acc.
  - idx_out <= phase[ACC_W-1 -: IDX_W].
  - idx_valid <= 1.
  - wrap <= sum[ACC_W].
  - The lfsr advances (taps 16,14,13,11) only on sample steps, and only when DITH_W>0.
- Coherent apply: when pending=1 and a sample step has sum[ACC_W]=1:
  - ftw_act and poff_act load from the shadow registers and pending clears.
  - The new values take effect from the next step.
- en=0 (and phase_clr=0): acc and idx_out hold; idx_valid <= 0; wrap <= 0.
- phase_clr=1, regardless of en:
  - acc <= 0; idx_valid <= 0; wrap <= 0.
  - If pending, the shadow registers are applied and pending clears.
- Same-edge accept and apply: a new accept with cfg_sync=1 cannot coincide with an apply, because cfg_ready=0 while pending. A cfg_sync=0 accept requires pending=0.

## Timing

- Latency: one cycle from the en edge to idx_valid/idx_out.
- The first sample after reset with poff=0 and DITH_W=0 is idx 0.
- Throughput: one index per clock with en held high.
- Immediate config: a word accepted at edge N is used by the step at edge N+1.
- Coherent config:
  - The apply happens at the edge where wrap is registered as 1.
  - cfg_ready rises on the edge following that apply.
  - Steps from the next edge onward use the new ftw/poff.
- Wrap timing: wrap is asserted alongside the last index before rollover (e.g. idx 255 for a 2^24 step).
- Reset mid-operation discards any pending shadow; no partial apply.

## Test plan

- Reset, immediate cfg ftw=0x0100_0000, poff=0, en held high → idx 0,1,…,255,0,1…; wrap=1 only alongside idx 255; idx_valid continuous.
- Immediate cfg ftw=0x0100_0000, poff=0x8000_0000 → first idx 128, 129…; wrap still alongside the physical-acc overflow sample (idx 127).
- Running at ftw=0x0100_0000; at idx 10, load ftw=0x0200_0000 with cfg_sync=1 → cfg_ready low, steps stay 1 through idx 255 (wrap=1), then 0,2,4…; cfg_ready returns high one cycle after the wrap.
- en toggled 1,0,0,1 → idx_valid 1,0,0,1 (one cycle delayed); idx_out holds during the gap; the sequence resumes without skipping a step.
- phase_clr pulsed with en=1 during a pending sync load of ftw=0x0300_0000 → that cycle idx_valid=0; next samples 0,3,6…; pending cleared.
- rst low one cycle while pending → next cycle all outputs 0 and cfg_ready 0; after release, steps at ftw 0 give idx_out 0 repeatedly with valid=1.
